// File: rtl/reset_sequencer.sv
// reset_sequencer: turns warm/cold reset request pulses into a timed system
// reset, zero-filling the shared main RAM on cold requests and at power-on.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned POST_CYCLES = 4,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic              reset_req_cold,
    output logic              clr_wren,
    output logic [ADDR_W-1:0] clr_addr,
    input  logic              clr_ack,
    output logic              sys_reset,
    output logic              busy,
    output logic              last_cold
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > POST_CYCLES) ? HOLD_CYCLES : POST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CLEAR = 2'd2,
        POST  = 2'd3
    } state_t;

    state_t           state;
    logic             cold_pend;
    logic [CNT_W-1:0] cnt;

    // Sequencer FSM with registered outputs; a request in any state restarts HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HOLD;
            cold_pend <= 1'b1;
            cnt       <= '0;
            clr_addr  <= '0;
            clr_wren  <= 1'b0;
            sys_reset <= 1'b1;
            busy      <= 1'b1;
            last_cold <= 1'b0;
        end else if (reset_req) begin
            // A pending or interrupted cold clear is never downgraded to warm.
            if (state == IDLE) begin
                cold_pend <= reset_req_cold;
            end else begin
                cold_pend <= cold_pend | reset_req_cold;
            end
            state     <= HOLD;
            cnt       <= '0;
            clr_addr  <= '0;
            clr_wren  <= 1'b0;
            sys_reset <= 1'b1;
            busy      <= 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (cold_pend) begin
                            state    <= CLEAR;
                            clr_addr <= '0;
                            clr_wren <= 1'b1;
                        end else begin
                            state     <= POST;
                            last_cold <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CLEAR: begin
                    if (clr_ack) begin
                        if (clr_addr == ADDR_LAST) begin
                            clr_wren  <= 1'b0;
                            cold_pend <= 1'b0;
                            last_cold <= 1'b1;
                            cnt       <= '0;
                            state     <= POST;
                        end else begin
                            clr_addr <= clr_addr + ADDR_W'(1);
                        end
                    end
                end
                POST: begin
                    if (cnt == POST_LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        sys_reset <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    sys_reset <= 1'b0;
                    busy      <= 1'b0;
                    clr_wren  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed vector table plus hand-written multi-cycle sequences.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_req;
    logic       reset_req_cold;
    logic       clr_wren;
    logic [2:0] clr_addr;
    logic       clr_ack;
    logic       sys_reset;
    logic       busy;
    logic       last_cold;

    int checks   = 0;
    int failures = 0;

    reset_sequencer #(
        .HOLD_CYCLES(4),
        .POST_CYCLES(2),
        .ADDR_W     (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reset_req     (reset_req),
        .reset_req_cold(reset_req_cold),
        .clr_wren      (clr_wren),
        .clr_addr      (clr_addr),
        .clr_ack       (clr_ack),
        .sys_reset     (sys_reset),
        .busy          (busy),
        .last_cold     (last_cold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic req;
        logic cold;
        logic ack;
        logic e_sys;
        logic e_busy;
        logic e_wren;
        logic e_lc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Count sys_reset-high cycles from the current negedge with ack held high;
    // also verify the clear addresses step 0,1,2,... on consecutive write cycles.
    task automatic run_count(output int n_sys, output int n_wr, output int addr_ok);
        n_sys   = 0;
        n_wr    = 0;
        addr_ok = 1;
        clr_ack = 1'b1;
        while (sys_reset && n_sys < 200) begin
            n_sys++;
            if (clr_wren) begin
                if (int'(clr_addr) != n_wr) addr_ok = 0;
                n_wr++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_addr(input int a, input string name);
        int n = 0;
        while (!(clr_wren && int'(clr_addr) == a) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, int'(clr_wren && int'(clr_addr) == a), 1);
    endtask

    task automatic count_until_wren(output int n);
        n = 0;
        while (!clr_wren && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_req(input logic cold);
        reset_req      = 1'b1;
        reset_req_cold = cold;
        @(negedge clk);
        reset_req      = 1'b0;
        reset_req_cold = 1'b0;
    endtask

    initial begin
        int n_sys, n_wr, addr_ok, n;
        int k, acks, exp_addr, started, gap_err, addr_err, post_n;
        logic ackv;

        // {req, cold, ack, e_sys, e_busy, e_wren, e_lc}, starting from IDLE after a cold sequence
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset          = 1'b1;
        reset_req      = 1'b0;
        reset_req_cold = 1'b0;
        clr_ack        = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_sys_reset", int'(sys_reset), 1);
        chk("rst_busy", int'(busy), 1);
        chk("rst_clr_wren", int'(clr_wren), 0);
        chk("rst_clr_addr", int'(clr_addr), 0);
        chk("rst_last_cold", int'(last_cold), 0);

        // Power-on cold sequence with ack tied high
        reset = 1'b0;
        run_count(n_sys, n_wr, addr_ok);
        chk("por_sys_cycles", n_sys, 14);
        chk("por_writes", n_wr, 8);
        chk("por_addr_seq", addr_ok, 1);
        chk("por_busy", int'(busy), 0);
        chk("por_last_cold", int'(last_cold), 1);

        // Warm sequence, ack/cold ignored where irrelevant, then a cold request
        for (int i = 0; i < 9; i++) begin
            reset_req      = vecs[i].req;
            reset_req_cold = vecs[i].cold;
            clr_ack        = vecs[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_sys_reset", i), int'(sys_reset), int'(vecs[i].e_sys));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_clr_wren", i), int'(clr_wren), int'(vecs[i].e_wren));
            chk($sformatf("vec%0d_last_cold", i), int'(last_cold), int'(vecs[i].e_lc));
        end
        reset_req      = 1'b0;
        reset_req_cold = 1'b0;
        clr_ack        = 1'b0;

        // Cold clear with ack only on every third write cycle
        k = 0; acks = 0; exp_addr = 0; started = 0; gap_err = 0; addr_err = 0; post_n = 0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            ackv = 1'b0;
            if (clr_wren) begin
                started = 1;
                if (int'(clr_addr) != exp_addr) addr_err++;
                ackv = ((k % 3) == 2);
                k++;
                if (ackv) begin
                    acks++;
                    exp_addr++;
                end
            end else begin
                if (started != 0 && acks < 8) gap_err++;
                if (acks == 8) post_n++;
            end
            clr_ack = ackv;
            @(negedge clk);
        end
        clr_ack = 1'b0;
        chk("slow_acks", acks, 8);
        chk("slow_wren_gaps", gap_err, 0);
        chk("slow_addr_errs", addr_err, 0);
        chk("slow_post_cycles", post_n, 2);
        chk("slow_sys_reset", int'(sys_reset), 0);
        chk("slow_last_cold", int'(last_cold), 1);

        // Warm request mid-clear at address 5 restarts the whole clear
        clr_ack = 1'b1;
        pulse_req(1'b1);
        wait_addr(5, "mid_wait_addr5");
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        chk("mid_restart_wren", int'(clr_wren), 0);
        chk("mid_restart_addr", int'(clr_addr), 0);
        chk("mid_restart_sys", int'(sys_reset), 1);
        count_until_wren(n);
        chk("mid_hold_cycles", n, 4);
        run_count(n_sys, n_wr, addr_ok);
        chk("mid_rest_cycles", n_sys, 10);
        chk("mid_writes", n_wr, 8);
        chk("mid_addr_seq", addr_ok, 1);
        chk("mid_last_cold", int'(last_cold), 1);

        // Warm sequence, then cold request in the first POST cycle
        pulse_req(1'b0);
        repeat (4) @(negedge clk);
        chk("post_last_cold_cleared", int'(last_cold), 0);
        chk("post_clr_wren", int'(clr_wren), 0);
        pulse_req(1'b1);
        run_count(n_sys, n_wr, addr_ok);
        chk("post_restart_cycles", n_sys, 14);
        chk("post_restart_writes", n_wr, 8);
        chk("post_restart_last_cold", int'(last_cold), 1);

        // Asynchronous reset mid-clear at address 3
        pulse_req(1'b1);
        wait_addr(3, "arst_wait_addr3");
        #1 reset = 1'b1;
        #1;
        chk("arst_clr_wren", int'(clr_wren), 0);
        chk("arst_clr_addr", int'(clr_addr), 0);
        chk("arst_sys_reset", int'(sys_reset), 1);
        chk("arst_last_cold", int'(last_cold), 0);
        @(negedge clk);
        reset = 1'b0;
        run_count(n_sys, n_wr, addr_ok);
        chk("arst_por_cycles", n_sys, 14);
        chk("arst_por_writes", n_wr, 8);
        chk("arst_last_cold_set", int'(last_cold), 1);

        // Warm sequence, then restart coinciding with the final clear ack
        pulse_req(1'b0);
        run_count(n_sys, n_wr, addr_ok);
        chk("warm_cycles", n_sys, 6);
        chk("warm_writes", n_wr, 0);
        chk("warm_last_cold", int'(last_cold), 0);
        pulse_req(1'b1);
        wait_addr(7, "final_wait_addr7");
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        chk("final_restart_wren", int'(clr_wren), 0);
        chk("final_restart_last_cold", int'(last_cold), 0);
        count_until_wren(n);
        chk("final_hold_cycles", n, 4);
        chk("final_reclear_addr", int'(clr_addr), 0);
        run_count(n_sys, n_wr, addr_ok);
        chk("final_writes", n_wr, 8);
        chk("final_last_cold", int'(last_cold), 1);
        chk("final_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
